// File: rtl/run_ctrl.sv
// Run-control sequencer: gates the core enable, counts run cycles and retired instructions,
// stops on halt (fixed drain) or timeout. Optional end-of-run report under RUN_CTRL_DISPLAY_EN.
module run_ctrl #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MAX_CYCLES   = 100000,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             isHalt,
    input  logic             W_v,
    output logic             cpu_en,
    output logic             done,
    output logic [1:0]       stop_reason,
    output logic [CNT_W-1:0] cycle,
    output logic [CNT_W-1:0] instr,
    input  logic             snap_req,
    output logic             snap_valid,
    input  logic             snap_ack,
    output logic [CNT_W-1:0] snap_cycle,
    output logic [CNT_W-1:0] snap_instr
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    localparam logic [1:0] ReasonNone    = 2'd0;
    localparam logic [1:0] ReasonHalt    = 2'd1;
    localparam logic [1:0] ReasonTimeout = 2'd2;

    // Drain counter needs at least one bit even when a single drain cycle is configured.
    localparam int unsigned       DrainW    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CycleLast = CNT_W'(MAX_CYCLES - 1);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);

    state_e              state_q, state_d;
    logic [1:0]          reason_q, reason_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [CNT_W-1:0]    instr_q, instr_d;
    logic [DrainW-1:0]   drain_q, drain_d;
    logic                snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0]    snap_cycle_q, snap_cycle_d;
    logic [CNT_W-1:0]    snap_instr_q, snap_instr_d;

    always_comb begin
        state_d  = state_q;
        reason_d = reason_q;
        cycle_d  = cycle_q;
        instr_d  = instr_q;
        drain_d  = drain_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StRun;
                    reason_d = ReasonNone;
                    cycle_d  = '0;
                    instr_d  = '0;
                    drain_d  = '0;
                end
            end
            StRun: begin
                cycle_d = cycle_q + CNT_W'(1);
                if (W_v) begin
                    instr_d = instr_q + CNT_W'(1);
                end
                // Halt wins over timeout when both land on the same cycle.
                if (isHalt) begin
                    state_d  = StDrain;
                    reason_d = ReasonHalt;
                    drain_d  = '0;
                end else if (cycle_q == CycleLast) begin
                    state_d  = StDone;
                    reason_d = ReasonTimeout;
                end
            end
            StDrain: begin
                if (W_v) begin
                    instr_d = instr_q + CNT_W'(1);
                end
                if (drain_q == DrainLast) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + DrainW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Snapshot holds until acknowledged; requests arriving while held are dropped.
    always_comb begin
        snap_valid_d = snap_valid_q;
        snap_cycle_d = snap_cycle_q;
        snap_instr_d = snap_instr_q;
        if (snap_valid_q) begin
            if (snap_ack) begin
                snap_valid_d = 1'b0;
            end
        end else if (snap_req) begin
            snap_valid_d = 1'b1;
            snap_cycle_d = cycle_q;
            snap_instr_d = instr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            reason_q     <= ReasonNone;
            cycle_q      <= '0;
            instr_q      <= '0;
            drain_q      <= '0;
            snap_valid_q <= 1'b0;
            snap_cycle_q <= '0;
            snap_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            reason_q     <= reason_d;
            cycle_q      <= cycle_d;
            instr_q      <= instr_d;
            drain_q      <= drain_d;
            snap_valid_q <= snap_valid_d;
            snap_cycle_q <= snap_cycle_d;
            snap_instr_q <= snap_instr_d;
        end
    end

    assign cpu_en      = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign stop_reason = reason_q;
    assign cycle       = cycle_q;
    assign instr       = instr_q;
    assign snap_valid  = snap_valid_q;
    assign snap_cycle  = snap_cycle_q;
    assign snap_instr  = snap_instr_q;

`ifdef RUN_CTRL_DISPLAY_EN
    real cpi_r;

    always @(posedge clk) begin
        if (rst_n && (state_q != StDone) && (state_d == StDone)) begin
            cpi_r = (instr_d == '0) ? 0.0 : (real'(cycle_d) / real'(instr_d));
            $display("run_ctrl: cycles=%0d instrs=%0d stop_reason=%0d CPI=%f",
                     cycle_d, instr_d, reason_d, cpi_r);
            if (reason_d == ReasonTimeout) begin
                $display("#ran for %0d cycles", MAX_CYCLES);
            end
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: stimulus queues expected end-of-run and snapshot results,
// a negedge monitor pops and compares them when done / snap_valid rise.
module tb_run_ctrl;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned MAXC  = 20;
    localparam int unsigned DRAIN = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             isHalt;
    logic             W_v;
    logic             cpu_en;
    logic             done;
    logic [1:0]       stop_reason;
    logic [CNT_W-1:0] cycle;
    logic [CNT_W-1:0] instr;
    logic             snap_req;
    logic             snap_valid;
    logic             snap_ack;
    logic [CNT_W-1:0] snap_cycle;
    logic [CNT_W-1:0] snap_instr;

    run_ctrl #(
        .CNT_W       (CNT_W),
        .MAX_CYCLES  (MAXC),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .isHalt     (isHalt),
        .W_v        (W_v),
        .cpu_en     (cpu_en),
        .done       (done),
        .stop_reason(stop_reason),
        .cycle      (cycle),
        .instr      (instr),
        .snap_req   (snap_req),
        .snap_valid (snap_valid),
        .snap_ack   (snap_ack),
        .snap_cycle (snap_cycle),
        .snap_instr (snap_instr)
    );

    typedef struct {
        logic [31:0] c;
        logic [31:0] i;
        logic [31:0] r;
        int          edge_n;
    } done_exp_t;

    typedef struct {
        logic [31:0] c;
        logic [31:0] i;
    } snap_exp_t;

    done_exp_t dq[$];
    snap_exp_t sq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 30) begin
            step();
            n++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    // Monitor: compares end-of-run and snapshot results as the DUT presents them.
    logic      done_prev = 1'b0;
    logic      snap_prev = 1'b0;
    snap_exp_t snap_cur;

    always @(negedge clk) begin
        done_exp_t de;
        if (done && !done_prev) begin
            if (dq.size() == 0) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                de = dq.pop_front();
                chk("done_edge", 32'(edge_cnt), 32'(de.edge_n));
                chk("done_cycle", cycle, de.c);
                chk("done_instr", instr, de.i);
                chk("done_reason", 32'(stop_reason), de.r);
                chk("done_cpu_en_low", 32'(cpu_en), 32'd0);
            end
        end
        if (snap_valid && !snap_prev) begin
            if (sq.size() == 0) begin
                chk("snap_unexpected", 32'd1, 32'd0);
                snap_cur.c = snap_cycle;
                snap_cur.i = snap_instr;
            end else begin
                snap_cur = sq.pop_front();
            end
        end
        if (snap_valid) begin
            chk("snap_cycle", snap_cycle, snap_cur.c);
            chk("snap_instr", snap_instr, snap_cur.i);
        end
        done_prev = done;
        snap_prev = snap_valid;
    end

    initial begin
        int h;
        int n0;
        rst_n    = 1'b1;
        start    = 1'b0;
        isHalt   = 1'b0;
        W_v      = 1'b0;
        snap_req = 1'b0;
        snap_ack = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cycle", cycle, 32'd0);
        chk("rst_snap_valid", 32'(snap_valid), 32'd0);
        #4 rst_n = 1'b1;
        step();

        // Halt in the 10th RUN cycle, W_v always high, start pulses in RUN and DRAIN.
        start = 1'b1;
        W_v   = 1'b1;
        step();
        start = 1'b0;
        chk("t1_cpu_en", 32'(cpu_en), 32'd1);
        chk("t1_cycle0", cycle, 32'd0);
        for (int k = 1; k <= 9; k++) begin
            start = (k == 3);
            step();
        end
        start = 1'b0;
        chk("t1_cycle9", cycle, 32'd9);
        isHalt = 1'b1;
        h = edge_cnt + 1;
        dq.push_back('{c: 32'd10, i: 32'd14, r: 32'd1, edge_n: h + DRAIN});
        step();
        isHalt = 1'b0;
        chk("t1_cpu_en_off", 32'(cpu_en), 32'd0);
        chk("t1_reason", 32'(stop_reason), 32'd1);
        chk("t1_cycle10", cycle, 32'd10);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done();

        // Restart from DONE; timeout with W_v on odd cycles, snapshot at cycle 5.
        start = 1'b1;
        W_v   = 1'b0;
        step();
        start = 1'b0;
        chk("t2_cpu_en", 32'(cpu_en), 32'd1);
        chk("t2_cycle_clr", cycle, 32'd0);
        chk("t2_instr_clr", instr, 32'd0);
        chk("t2_reason_clr", 32'(stop_reason), 32'd0);
        chk("t2_done_clr", 32'(done), 32'd0);
        n0 = edge_cnt;
        dq.push_back('{c: 32'd20, i: 32'd10, r: 32'd2, edge_n: n0 + 20});
        for (int k = 1; k <= 20; k++) begin
            W_v      = k[0];
            snap_req = (k == 6) || (k == 8) || (k == 9);
            snap_ack = (k == 9);
            if (k == 6) sq.push_back('{c: 32'd5, i: 32'd3});
            step();
            if (k == 9 || k == 10) chk("t2_snap_valid_low", 32'(snap_valid), 32'd0);
        end
        W_v      = 1'b0;
        snap_req = 1'b0;
        snap_ack = 1'b0;
        wait_done();

        // Halt on the cycle that would reach MAX_CYCLES.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        chk("t3_cycle19", cycle, 32'd19);
        isHalt = 1'b1;
        h = edge_cnt + 1;
        dq.push_back('{c: MAXC, i: 32'd0, r: 32'd1, edge_n: h + DRAIN});
        step();
        isHalt = 1'b0;
        chk("t3_cycle_max", cycle, MAXC);
        chk("t3_reason", 32'(stop_reason), 32'd1);
        chk("t3_cpu_en", 32'(cpu_en), 32'd0);
        chk("t3_done", 32'(done), 32'd0);
        wait_done();

        // Asynchronous reset in DRAIN with a snapshot held.
        start = 1'b1;
        W_v   = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        isHalt = 1'b1;
        step();
        isHalt   = 1'b0;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        chk("t4_snap_held", 32'(snap_valid), 32'd1);
        chk("t4_instr", instr, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("t4_rst_done", 32'(done), 32'd0);
        chk("t4_rst_reason", 32'(stop_reason), 32'd0);
        chk("t4_rst_cycle", cycle, 32'd0);
        chk("t4_rst_instr", instr, 32'd0);
        chk("t4_rst_snap_valid", 32'(snap_valid), 32'd0);
        chk("t4_rst_snap_cycle", snap_cycle, 32'd0);
        chk("t4_rst_snap_instr", snap_instr, 32'd0);
        #3 rst_n = 1'b1;
        W_v = 1'b0;
        step();
        chk("t4_idle_cpu_en", 32'(cpu_en), 32'd0);
        chk("t4_idle_done", 32'(done), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("t4_restart_cycle", cycle, 32'd2);
        chk("t4_restart_instr", instr, 32'd0);

        chk("done_queue_empty", 32'(dq.size()), 32'd0);
        chk("snap_queue_empty", 32'(sq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run-control and performance-count sequencer for the pipelined core testbench. It starts a run, gates the core enable, and counts cycles and retired instructions. It stops on halt (with a fixed pipeline drain) or on a cycle-budget timeout, and reports why the run ended. It also provides a snapshot handshake so a monitor can read coherent count pairs mid-run.

## Interface
- CNT_W, 32, width of cycle and instruction counters
- MAX_CYCLES, 100000, run-cycle budget; must be < 2^CNT_W and ≥ 1
- DRAIN_CYCLES, 4, post-halt drain length in cycles; ≥ 1

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled in IDLE or DONE only
- isHalt  in  1  halt instruction reached writeback
- W_v  in  1  one instruction retired this cycle
- cpu_en  out  1  core enable; high only in RUN
- done  out  1  run finished; high only in DONE
- stop_reason  out  2  0 NONE, 1 HALT, 2 TIMEOUT
- cycle  out  CNT_W  cycles spent in RUN
- instr  out  CNT_W  instructions retired in RUN and DRAIN
- snap_req  in  1  request a snapshot
- snap_valid  out  1  snapshot held
- snap_ack  in  1  consumer accepted snapshot
- snap_cycle  out  CNT_W  captured cycle
- snap_instr  out  CNT_W  captured instr

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. All outputs are registered or a pure decode of state.
- IDLE: start=1 → RUN. The same edge clears cycle, instr, stop_reason and the drain counter.
- RUN:
  - cycle increments every cycle.
  - instr increments when W_v=1.
  - isHalt=1 → DRAIN with stop_reason=HALT. cycle still counts that cycle.
  - Else, if cycle == MAX_CYCLES-1 (this increment reaches MAX_CYCLES) → DONE with stop_reason=TIMEOUT. There is no drain on timeout.
  - Halt beats timeout in the same cycle.
- DRAIN:
  - cycle frozen.
  - instr still increments on W_v.
  - isHalt ignored.
  - Drain counter runs 0..DRAIN_CYCLES-1, then → DONE.
- DONE:
  - All counts and stop_reason held.
  - start=1 → clear as in IDLE → RUN.
- start is ignored in RUN and DRAIN.
- Snapshot:
  - When snap_req=1 and snap_valid=0 in any state, capture the current (pre-increment) cycle and instr. snap_valid=1 from the next cycle.
  - snap_valid holds, and the captured data stays stable, until snap_ack=1. snap_valid clears on the following edge.
  - snap_req while snap_valid=1 is dropped, including on the ack cycle.
  - snap_ack while snap_valid=0 has no effect.
- Counters are unsigned, CNT_W wide. The MAX_CYCLES rule prevents cycle wrap. instr wraps modulo 2^CNT_W.

## Timing
- Reset (asynchronous, any state, including mid-run or mid-drain):
  - state=IDLE
  - cpu_en=0, done=0, stop_reason=0, cycle=0, instr=0
  - snap_valid=0, snap_cycle=0, snap_instr=0
  - drain counter=0
- start high at edge N → cpu_en=1 after edge N. The first counted cycle is the one ending at edge N+1.
- isHalt high in the cycle ending at edge H → cpu_en=0 after H. done=1 after edge H+DRAIN_CYCLES.
- Timeout: done=1 and cpu_en=0 after the edge where cycle becomes MAX_CYCLES. Final cycle reads MAX_CYCLES.
- Snapshot latency is 1 cycle from req to valid, and 1 cycle from ack to valid low.
- No combinational path from any input to any output.

## Configuration
- RUN_CTRL_DISPLAY_EN defined:
  - On entry to DONE, simulation prints the cycle count, instr count, stop_reason and CPI = cycle/instr (real; prints 0 if instr=0).
  - TIMEOUT additionally prints "#ran for MAX_CYCLES cycles". Then it calls $finish.
- RUN_CTRL_DISPLAY_EN undefined: no system tasks. The block stays in DONE awaiting start. The RTL is synthesizable.

## Test plan
- Reset, then start pulse. Drive W_v every cycle, and isHalt in the 10th RUN cycle, DRAIN_CYCLES=4.
  - Required: cycle=10, stop_reason=1, done rises 4 cycles after halt.
  - Required: instr=14 if W_v stays high through drain.
- MAX_CYCLES=20, no halt, W_v every other cycle.
  - Required: done with cycle=20, instr=10, stop_reason=2, cpu_en low the same cycle done rises.
- isHalt asserted in the cycle that would reach MAX_CYCLES.
  - Required: stop_reason=1, the block enters DRAIN, cycle=MAX_CYCLES.
- snap_req at RUN cycle 5 with W_v constant, ack held off 3 cycles.
  - Required: snap_cycle=5 (pre-increment), data stable while valid, a second req during valid is dropped, valid low 1 cycle after ack.
- rst_n asserted mid-DRAIN.
  - Required: all outputs 0 immediately (asynchronous), state IDLE. A new start gives cycle restarting from 0.
- From DONE, start pulse.
  - Required: counts and stop_reason clear, cpu_en=1 the next cycle. start pulses during RUN and DRAIN have no effect.
